mips_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers for the 5-stage MIPS pipeline.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO issued from the EXE stage.
- Width is parametrised.
- Raises a stall request to the hazard/control logic while an operation is in flight and a dependent instruction (new mul/div, MFHI/MFLO) needs the unit.

---
 rtl/mips_muldiv_unit_pkg.sv | 22 ++
 rtl/mips_muldiv_unit_if.sv | 26 ++
 rtl/mdu_step.sv | 39 +++
 rtl/mips_muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_muldiv_unit_pkg.sv
// Shared op codes and FSM state encoding for the MIPS multiply/divide unit.
package mips_muldiv_unit_pkg;

    localparam logic [2:0] MDU_NOP   = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    function automatic logic mdu_is_muldiv(input logic [2:0] op);
        return (op >= MDU_MULT) && (op <= MDU_DIVU);
    endfunction

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// EXE-stage request/response bundle between the pipeline and the multiply/divide unit.
interface mips_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cancel;
    logic             hilo_read;
    logic             busy;
    logic             done;
    logic             stall_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, opa, opb, cancel, hilo_read,
        input  busy, done, stall_req, hi, lo
    );

    modport slave (
        input  start, op, opa, opb, cancel, hilo_read,
        output busy, done, stall_req, hi, lo
    );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] part_hi,
    input  logic [WIDTH-1:0] part_lo,
    input  logic [WIDTH-1:0] operand,
    input  logic             is_div,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The remainder stays below the divisor, so the difference always fits WIDTH bits.
    always_comb begin
        sum     = {1'b0, part_hi} + {1'b0, operand};
        shifted = {part_hi, part_lo[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - operand;
        next_hi = part_hi;
        next_lo = part_lo;
        if (is_div) begin
            if (shifted >= {1'b0, operand}) begin
                next_hi = diff;
                next_lo = {part_lo[WIDTH-2:0], 1'b1};
            end else begin
                next_hi = shifted[WIDTH-1:0];
                next_lo = {part_lo[WIDTH-2:0], 1'b0};
            end
        end else if (part_lo[0]) begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], part_lo[WIDTH-1:1]};
        end else begin
            next_hi = {1'b0, part_hi[WIDTH-1:1]};
            next_lo = {part_hi[0], part_lo[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Defining MDU_FAST_ZERO_EN skips the iterations for multiplies by zero and divides by zero.
module mips_muldiv_unit
    import mips_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    mips_muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   part_hi, part_lo, operand, dividend_raw;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               is_div, neg_main, neg_rem, div_zero, done_q;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic               op_muldiv, op_div, op_signed, accept, fast_zero, busy;
    logic [WIDTH-1:0]   mag_a, mag_b, fin_hi, fin_lo;
    logic [2*WIDTH-1:0] product_fix;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .part_hi (part_hi),
        .part_lo (part_lo),
        .operand (operand),
        .is_div  (is_div),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_comb begin
        op_muldiv = mdu_is_muldiv(bus.op);
        op_div    = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
        op_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
        mag_a     = (op_signed && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
        mag_b     = (op_signed && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;
        accept    = (state == S_IDLE) && bus.start && !bus.cancel && op_muldiv;
`ifdef MDU_FAST_ZERO_EN
        fast_zero = op_div ? (bus.opb == '0) : ((bus.opa == '0) || (bus.opb == '0));
`else
        fast_zero = 1'b0;
`endif
    end

    // Divide-by-zero bypasses sign correction so HI returns the dividend untouched.
    always_comb begin
        product_fix = neg_main ? -{part_hi, part_lo} : {part_hi, part_lo};
        fin_hi      = product_fix[2*WIDTH-1:WIDTH];
        fin_lo      = product_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                fin_hi = dividend_raw;
                fin_lo = '1;
            end else begin
                fin_hi = neg_rem  ? -part_hi : part_hi;
                fin_lo = neg_main ? -part_lo : part_lo;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_nxt = fast_zero ? S_FINISH : S_CALC;
            end
            S_CALC: begin
                if (bus.cancel)
                    state_nxt = S_IDLE;
                else if (count == CNT_W'(WIDTH - 1))
                    state_nxt = S_FINISH;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Multiply keeps the multiplier in part_lo; divide shifts the dividend out of part_lo.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            count        <= '0;
            part_hi      <= '0;
            part_lo      <= '0;
            operand      <= '0;
            dividend_raw <= '0;
            is_div       <= 1'b0;
            neg_main     <= 1'b0;
            neg_rem      <= 1'b0;
            div_zero     <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            done_q       <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        count        <= '0;
                        part_hi      <= '0;
                        part_lo      <= op_div ? mag_a : (fast_zero ? '0 : mag_b);
                        operand      <= op_div ? mag_b : mag_a;
                        dividend_raw <= bus.opa;
                        is_div       <= op_div;
                        neg_main     <= op_signed && (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
                        neg_rem      <= op_signed && bus.opa[WIDTH-1];
                        div_zero     <= op_div && (bus.opb == '0);
                    end else if (bus.start && !bus.cancel && bus.op == MDU_MTHI) begin
                        hi_q <= bus.opa;
                    end else if (bus.start && !bus.cancel && bus.op == MDU_MTLO) begin
                        lo_q <= bus.opa;
                    end
                end
                S_CALC: begin
                    if (!bus.cancel) begin
                        part_hi <= step_hi;
                        part_lo <= step_lo;
                        count   <= count + CNT_W'(1);
                    end
                end
                S_FINISH: begin
                    if (!bus.cancel) begin
                        hi_q   <= fin_hi;
                        lo_q   <= fin_lo;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state != S_IDLE);
    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.stall_req = busy & (bus.start | bus.hilo_read);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed scenarios plus a randomized run against an arithmetic model.
module tb_mips_muldiv_unit;
    import mips_muldiv_unit_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [W-1:0] m_hi, m_lo;

    mips_muldiv_unit_if #(.WIDTH(W)) bus ();

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference results straight from integer arithmetic; {hi, lo}.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ref_result = 64'd0;
        case (op)
            3'd1: ref_result = 64'(sa * sb);
            3'd2: ref_result = ua * ub;
            3'd3: begin
                if (b == 32'd0) ref_result = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    ref_result = {32'(r), 32'(q)};
                end
            end
            3'd4: begin
                if (b == 32'd0) ref_result = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    ref_result = {ur[31:0], uq[31:0]};
                end
            end
            default: ref_result = 64'd0;
        endcase
    endfunction

    function automatic int exp_cycles(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 3'd1 || op > 3'd4) return 0;
`ifdef MDU_FAST_ZERO_EN
        if ((op == 3'd3 || op == 3'd4) && b == 32'd0) return 1;
        if ((op == 3'd1 || op == 3'd2) && (a == 32'd0 || b == 32'd0)) return 1;
`endif
        return W + 1;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output logic done_seen);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = MDU_NOP;
        cycles    = 0;
        while (bus.busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(posedge clk); #1;
        end
        done_seen = bus.done;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.op = MDU_NOP; bus.opa = 0; bus.opb = 0;
        bus.cancel = 0; bus.hilo_read = 1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %b want 0", bus.stall_req); end
        n_cmp++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_hilo: got %h/%h want 0/0", bus.hi, bus.lo); end
        bus.hilo_read = 0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int cyc; logic dn;
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, dn);
        n_cmp++; if (cyc != W + 1) begin n_fail++; $display("[TB] FAIL multu_busy_cycles: got %0d want %0d", cyc, W + 1); end
        n_cmp++; if (dn !== 1'b1) begin n_fail++; $display("[TB] FAIL multu_done: got %b want 1", dn); end
        n_cmp++; if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin n_fail++; $display("[TB] FAIL multu_result: got %h/%h want fffffffe/00000001", bus.hi, bus.lo); end
        @(posedge clk); #1;
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL done_one_cycle: got %b want 0", bus.done); end
        run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, cyc, dn);
        n_cmp++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin n_fail++; $display("[TB] FAIL mult_neg: got %h/%h want ffffffff/ffffffeb", bus.hi, bus.lo); end
    endtask

    task automatic test_div();
        int cyc; logic dn;
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, cyc, dn);
        n_cmp++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("[TB] FAIL div_neg: got %h/%h want ffffffff/fffffffd", bus.hi, bus.lo); end
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, dn);
        n_cmp++; if (bus.hi !== 32'd0 || bus.lo !== 32'h8000_0000) begin n_fail++; $display("[TB] FAIL div_overflow: got %h/%h want 00000000/80000000", bus.hi, bus.lo); end
        run_op(MDU_DIVU, 32'd7, 32'd0, cyc, dn);
        n_cmp++; if (bus.hi !== 32'd7 || bus.lo !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL divu_zero: got %h/%h want 00000007/ffffffff", bus.hi, bus.lo); end
        n_cmp++; if (cyc != exp_cycles(MDU_DIVU, 32'd7, 32'd0)) begin n_fail++; $display("[TB] FAIL divzero_busy_cycles: got %0d want %0d", cyc, exp_cycles(MDU_DIVU, 32'd7, 32'd0)); end
        n_cmp++; if (dn !== 1'b1) begin n_fail++; $display("[TB] FAIL divzero_done: got %b want 1", dn); end
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd0, cyc, dn);
        n_cmp++; if (bus.hi !== 32'hFFFF_FFF9 || bus.lo !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL div_signed_zero: got %h/%h want fffffff9/ffffffff", bus.hi, bus.lo); end
    endtask

    task automatic test_stall();
        int cyc; logic dn;
        logic [63:0] res;
        logic exp_busy, exp_stall;
        run_op(MDU_MTHI, 32'hAAAA_0000, 32'd0, cyc, dn);
        run_op(MDU_MTLO, 32'h0000_BBBB, 32'd0, cyc, dn);
        res = ref_result(MDU_MULT, 32'h1234_5678, 32'hFEDC_BA98);
        bus.start = 1'b1; bus.op = MDU_MULT; bus.opa = 32'h1234_5678; bus.opb = 32'hFEDC_BA98;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= W + 2; c++) begin
            bus.hilo_read = (c >= 5);
            if (c == 10) begin
                bus.start = 1'b1; bus.op = MDU_MULTU; bus.opa = 32'd3; bus.opb = 32'd5;
            end else begin
                bus.start = 1'b0; bus.op = MDU_NOP;
            end
            #1;
            exp_busy  = (c <= W + 1);
            exp_stall = exp_busy && (c >= 5);
            n_cmp++; if (bus.busy !== exp_busy) begin n_fail++; $display("[TB] FAIL stall_busy c%0d: got %b want %b", c, bus.busy, exp_busy); end
            n_cmp++; if (bus.stall_req !== exp_stall) begin n_fail++; $display("[TB] FAIL stall_req c%0d: got %b want %b", c, bus.stall_req, exp_stall); end
            if (c <= W + 1) begin
                n_cmp++; if (bus.hi !== 32'hAAAA_0000 || bus.lo !== 32'h0000_BBBB) begin n_fail++; $display("[TB] FAIL stale_hilo c%0d: got %h/%h want aaaa0000/0000bbbb", c, bus.hi, bus.lo); end
            end else begin
                n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_done: got %b want 1", bus.done); end
                n_cmp++; if ({bus.hi, bus.lo} !== res) begin n_fail++; $display("[TB] FAIL stall_result: got %h%h want %h", bus.hi, bus.lo, res); end
            end
            @(posedge clk); #1;
        end
        bus.hilo_read = 1'b0;
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ignored_start: busy got %b want 0", bus.busy); end
    endtask

    task automatic test_mtxx_cancel();
        int cyc; logic dn; logic done_any;
        run_op(MDU_MTLO, 32'h0000_1234, 32'd0, cyc, dn);
        n_cmp++; if (bus.lo !== 32'h0000_1234 || cyc != 0 || dn !== 1'b0) begin n_fail++; $display("[TB] FAIL mtlo: got lo=%h cyc=%0d done=%b want 00001234/0/0", bus.lo, cyc, dn); end
        run_op(MDU_MTHI, 32'h0000_5678, 32'd0, cyc, dn);
        n_cmp++; if (bus.hi !== 32'h0000_5678 || cyc != 0 || dn !== 1'b0) begin n_fail++; $display("[TB] FAIL mthi: got hi=%h cyc=%0d done=%b want 00005678/0/0", bus.hi, cyc, dn); end
        bus.start = 1'b1; bus.op = MDU_DIV; bus.opa = 32'd1000; bus.opb = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            bus.cancel = (c == 10);
            n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL cancel_pre_busy c%0d: got %b want 1", c, bus.busy); end
            @(posedge clk); #1;
        end
        bus.cancel = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel_idle: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
        done_any = 1'b0;
        for (int c = 0; c < W + 4; c++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_any = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (done_any !== 1'b0) begin n_fail++; $display("[TB] FAIL cancel_no_done: activity got %b want 0", done_any); end
        n_cmp++; if (bus.hi !== 32'h0000_5678 || bus.lo !== 32'h0000_1234) begin n_fail++; $display("[TB] FAIL cancel_hilo: got %h/%h want 00005678/00001234", bus.hi, bus.lo); end
        bus.cancel = 1'b1;
        run_op(MDU_MTHI, 32'hDEAD_BEEF, 32'd0, cyc, dn);
        n_cmp++; if (bus.hi !== 32'h0000_5678) begin n_fail++; $display("[TB] FAIL cancel_beats_mthi: got %h want 00005678", bus.hi); end
        run_op(MDU_MULT, 32'd9, 32'd9, cyc, dn);
        n_cmp++; if (cyc != 0) begin n_fail++; $display("[TB] FAIL cancel_beats_start: busy cycles got %0d want 0", cyc); end
        bus.cancel = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc; logic dn;
        bus.start = 1'b1; bus.op = MDU_MULT; bus.opa = 32'd11; bus.opb = 32'd13;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_ctrl: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
        n_cmp++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin n_fail++; $display("[TB] FAIL midreset_hilo: got %h/%h want 0/0", bus.hi, bus.lo); end
        run_op(MDU_MULT, 32'd2, 32'd3, cyc, dn);
        n_cmp++; if (bus.hi !== 32'd0 || bus.lo !== 32'd6 || dn !== 1'b1 || cyc != W + 1) begin n_fail++; $display("[TB] FAIL post_reset_mult: got %h/%h done=%b cyc=%0d want 0/6/1/%0d", bus.hi, bus.lo, dn, cyc, W + 1); end
    endtask

    task automatic test_random();
        int cyc; logic dn;
        logic [2:0] op;
        logic [31:0] a, b;
        logic [63:0] res;
        m_hi = $urandom; m_lo = $urandom;
        run_op(MDU_MTHI, m_hi, 32'd0, cyc, dn);
        run_op(MDU_MTLO, m_lo, 32'd0, cyc, dn);
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) op = 3'($urandom_range(1, 4));
            case ($urandom_range(0, 5))
                0: a = 32'd0;
                1: a = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: a = 32'($urandom_range(0, 100));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'd1;
                3: b = 32'($urandom_range(0, 100));
                default: b = $urandom;
            endcase
            run_op(op, a, b, cyc, dn);
            if (op >= 3'd1 && op <= 3'd4) begin
                res = ref_result(op, a, b);
                m_hi = res[63:32];
                m_lo = res[31:0];
            end else if (op == 3'd5) m_hi = a;
            else if (op == 3'd6) m_lo = a;
            n_cmp++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin n_fail++; $display("[TB] FAIL rand%0d op%0d %h,%h: got %h/%h want %h/%h", i, op, a, b, bus.hi, bus.lo, m_hi, m_lo); end
            n_cmp++; if (cyc != exp_cycles(op, a, b) || dn !== (op >= 3'd1 && op <= 3'd4)) begin n_fail++; $display("[TB] FAIL rand%0d_timing op%0d: got cyc=%0d done=%b want cyc=%0d", i, op, cyc, dn, exp_cycles(op, a, b)); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_stall();
        test_mtxx_cancel();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
